// File: rtl/a_lkp_engine.sv
// Lookup-engine stand-in for block A: accepts tagged lookup requests and returns
// results after a key-dependent latency, so responses may complete out of order.
module a_lkp_engine #(
    parameter int INFO_W   = 16,
    parameter int ID_W     = 6,
    parameter int RSLT_W   = 8,
    parameter int DEPTH    = 8,
    parameter int BASE_LAT = 4,
    localparam int OCC_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c2a_lkp_vld,
    input  logic [INFO_W-1:0] c2a_lkp_info,
    input  logic [ID_W-1:0]   c2a_lkp_req_id,
    output logic              a2c_lkp_rdy,
    output logic              a2c_lkp_rsp_vld,
    output logic [ID_W-1:0]   a2c_lkp_rsp_id,
    output logic [RSLT_W-1:0] a2c_lkp_rslt,
    input  logic              lkp_stall,
    output logic [OCC_W-1:0]  lkp_occ
);

    localparam int CNT_W = $clog2(BASE_LAT + 4);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Handshake: a request is taken on any edge where c2a_lkp_vld and a2c_lkp_rdy are
    // both high; rdy never looks at vld. Responses are single-cycle pulses, no backpressure.

    logic [DEPTH-1:0]  slot_vld_q;
    logic [DEPTH-1:0]  slot_vld_d;
    logic [ID_W-1:0]   slot_id_q   [DEPTH];
    logic [RSLT_W-1:0] slot_rslt_q [DEPTH];
    logic [CNT_W-1:0]  slot_cnt_q  [DEPTH];
    logic              rdy_en_q;

    logic              accept;
    logic              issue_found;
    logic [IDX_W-1:0]  alloc_idx;
    logic [IDX_W-1:0]  issue_idx;
    logic [OCC_W-1:0]  occ_d;
    logic [RSLT_W-1:0] req_rslt;
    logic [CNT_W-1:0]  req_cnt;

    assign a2c_lkp_rdy = rdy_en_q & ~lkp_stall & (lkp_occ < OCC_W'(DEPTH));
    assign accept      = c2a_lkp_vld & a2c_lkp_rdy;
    assign req_rslt    = c2a_lkp_info[RSLT_W-1:0] ^ c2a_lkp_info[INFO_W-1 -: RSLT_W];
    assign req_cnt     = CNT_W'(BASE_LAT) + {{(CNT_W-2){1'b0}}, c2a_lkp_info[1:0]};

    // Scanning from the top down leaves the lowest matching index in each pick.
    always_comb begin
        alloc_idx   = '0;
        issue_idx   = '0;
        issue_found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!slot_vld_q[i]) begin
                alloc_idx = IDX_W'(i);
            end
            if (slot_vld_q[i] && (slot_cnt_q[i] == '0)) begin
                issue_idx   = IDX_W'(i);
                issue_found = 1'b1;
            end
        end

        // Alloc picks a free slot and issue a busy one, so they never collide.
        slot_vld_d = slot_vld_q;
        if (issue_found) begin
            slot_vld_d[issue_idx] = 1'b0;
        end
        if (accept) begin
            slot_vld_d[alloc_idx] = 1'b1;
        end

        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OCC_W'(slot_vld_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_vld_q      <= '0;
            rdy_en_q        <= 1'b0;
            a2c_lkp_rsp_vld <= 1'b0;
            a2c_lkp_rsp_id  <= '0;
            a2c_lkp_rslt    <= '0;
            lkp_occ         <= '0;
        end else begin
            rdy_en_q        <= 1'b1;
            slot_vld_q      <= slot_vld_d;
            lkp_occ         <= occ_d;
            a2c_lkp_rsp_vld <= issue_found;
            if (issue_found) begin
                a2c_lkp_rsp_id <= slot_id_q[issue_idx];
                a2c_lkp_rslt   <= slot_rslt_q[issue_idx];
            end
        end
    end

    // Slot payload is only meaningful while its valid bit is set, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && (alloc_idx == IDX_W'(i))) begin
                slot_id_q[i]   <= c2a_lkp_req_id;
                slot_rslt_q[i] <= req_rslt;
                slot_cnt_q[i]  <= req_cnt;
            end else if (slot_vld_q[i] && (slot_cnt_q[i] != '0)) begin
                slot_cnt_q[i]  <= slot_cnt_q[i] - 1'b1;
            end
        end
    end

endmodule
